csr_access_controller: RTL

Core-side initiator for the CSR bus. It executes one RISC-V Zicsr instruction at a time (CSRRW/RS/RC and their immediate forms) by sequencing a read cycle and a write cycle on the shared CSR bus that all CSR data registers decode. It returns the old CSR value to the pipeline and flags illegal accesses. The block sits between the core's execute stage and the CSR bus fan-out.

---
 rtl/csr_access_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/csr_access_controller.sv
// Zicsr initiator: sequences one read and/or one write cycle on the CSR bus per instruction.
// Latency accept->done: 3 (read+write), 2 (read or write only), 1 (illegal at decode); no queueing, pipeline stalls on busy.
module csr_access_controller #(
   parameter bit READONLY_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instrValid,
   input  logic [2:0]  instrOp,
   input  logic [11:0] instrAddress,
   input  logic [31:0] instrOperand,
   input  logic        operandIsZero,
   input  logic        rdIsZero,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        illegal,
   output logic        csrReadEnable,
   output logic        csrWriteEnable,
   output logic [11:0] csrAddress,
   output logic [31:0] csrWriteData,
   input  logic [31:0] csrReadData,
   input  logic        csrRequestOutput
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

   state_e      state_q, state_d;
   logic [1:0]  kind_q, kind_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] operand_q, operand_d;
   logic        do_write_q, do_write_d;
   logic [31:0] result_q, result_d;
   logic        illegal_q, illegal_d;
   logic [31:0] wdata_q, wdata_d;

   function automatic logic op_valid(input logic [2:0] op);
      case (op)
         3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111: op_valid = 1'b1;
         default:                                          op_valid = 1'b0;
      endcase
   endfunction

   // kind is funct3[1:0]: 01 write, 10 set, 11 clear (immediate forms share it)
   function automatic logic is_rw(input logic [1:0] kind);
      is_rw = (kind == 2'b01);
   endfunction

   function automatic logic ro_violation(input logic [11:0] addr);
      ro_violation = READONLY_CHECK && (addr[11:10] == 2'b11);
   endfunction

   function automatic logic [31:0] new_value(input logic [1:0]  kind,
                                             input logic [31:0] old,
                                             input logic [31:0] operand);
      case (kind)
         2'b01:   new_value = operand;
         2'b10:   new_value = old | operand;
         2'b11:   new_value = old & ~operand;
         default: new_value = '0;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      addr_d     = addr_q;
      operand_d  = operand_q;
      do_write_d = do_write_q;
      result_d   = result_q;
      illegal_d  = illegal_q;
      wdata_d    = '0;

      case (state_q)
         IDLE: begin
            if (instrValid) begin
               kind_d     = instrOp[1:0];
               addr_d     = instrAddress;
               operand_d  = instrOperand;
               do_write_d = is_rw(instrOp[1:0]) || !operandIsZero;
               result_d   = '0;
               illegal_d  = 1'b0;
               if (!op_valid(instrOp)) begin
                  state_d   = DONE;
                  illegal_d = 1'b1;
               end else if (!(is_rw(instrOp[1:0]) && rdIsZero)) begin
                  state_d = READ;
               end else if (ro_violation(instrAddress)) begin
                  state_d   = DONE;
                  illegal_d = 1'b1;
               end else begin
                  // No read happened, so the old value seen by the update is 0
                  state_d = WRITE;
                  wdata_d = new_value(instrOp[1:0], '0, instrOperand);
               end
            end
         end
         READ: begin
            result_d = csrReadData;
            if (!csrRequestOutput) begin
               state_d   = DONE;
               illegal_d = 1'b1;
            end else if (do_write_q && ro_violation(addr_q)) begin
               state_d   = DONE;
               illegal_d = 1'b1;
            end else if (do_write_q) begin
               state_d = WRITE;
               wdata_d = new_value(kind_q, csrReadData, operand_q);
            end else begin
               state_d = DONE;
            end
         end
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         kind_q     <= '0;
         addr_q     <= '0;
         operand_q  <= '0;
         do_write_q <= 1'b0;
         result_q   <= '0;
         illegal_q  <= 1'b0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         addr_q     <= addr_d;
         operand_q  <= operand_d;
         do_write_q <= do_write_d;
         result_q   <= result_d;
         illegal_q  <= illegal_d;
         wdata_q    <= wdata_d;
      end
   end

   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE);
   assign csrReadEnable  = (state_q == READ);
   assign csrWriteEnable = (state_q == WRITE);
   assign csrAddress     = (state_q == IDLE) ? '0 : addr_q;
   assign csrWriteData   = wdata_q;
   assign result         = result_q;
   assign illegal        = illegal_q;

endmodule
